sdram_readback_checker: RTL and testbench

Verifies the frame image that the ROM-to-SDRAM loader wrote into SDRAM. It reads every pixel back through the SDRAM controller's read port and compares each one against the image ROM. It sits beside the loader: the loader is the writer and this block is the reader. Start it after the loader reports done. Results (pass/fail, error count, first failing address, timeout) drive status LEDs and debug taps.

---
 rtl/sdram_vga_pkg.sv | 28 ++
 rtl/sdram_readback_checker.sv | 143 ++++++++++++++
 tb/tb_sdram_readback_checker.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_vga_pkg
//  Brief    : Shared widths, frame constants and checker state type for the
//             ROM-to-SDRAM frame path (loader and readback checker).
//  Revision : 1.0 - initial release
// ============================================================================
package sdram_vga_pkg;

   localparam int PIXEL_W      = 3;
   localparam int SDRAM_DATA_W = 16;
   localparam int SDRAM_ADDR_W = 20;
   localparam int ROM_ADDR_W   = 17;

   localparam int FRAME_W      = 320;
   localparam int FRAME_H      = 240;

   // Readback checker states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_CMP  = 3'd3,
      ST_DONE = 3'd4
   } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_readback_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_readback_checker
//  Brief    : Reads every pixel of the frame back from SDRAM and compares it
//             with the image ROM; reports pass/fail, error count, first
//             failing pixel and read timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_readback_checker
   import sdram_vga_pkg::*;
#(
   parameter int                      NUM_PIXELS     = 76800,
   parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR      = 20'h00000,
   parameter int                      TIMEOUT_CYCLES = 1024,
   parameter int                      ERR_W          = 16
)(
   input  logic                      clk_50MHz,
   input  logic                      reset_sync_143,
   input  logic                      start,
   output logic                      start_read,
   output logic [SDRAM_ADDR_W-1:0]   read_addr,
   input  logic [SDRAM_DATA_W-1:0]   read_pixel,
   input  logic                      read_valid,
   output logic [ROM_ADDR_W-1:0]     rom_addr,
   input  logic [PIXEL_W-1:0]        rom_pixel,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [ERR_W-1:0]          error_count,
   output logic [ROM_ADDR_W-1:0]     first_err_addr
);

   localparam int                      c_TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [c_TMR_W-1:0]      c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ROM_ADDR_W-1:0]   c_IDX_LAST = ROM_ADDR_W'(NUM_PIXELS - 1);

   chk_state_t                r_state;
   chk_state_t                w_state_next;
   logic [ROM_ADDR_W-1:0]     r_idx;
   logic [ROM_ADDR_W-1:0]     w_req_idx;
   logic [c_TMR_W-1:0]        r_timer;
   logic [SDRAM_DATA_W-1:0]   r_rd_pixel;
   logic                      w_start_pass;
   logic                      w_timer_expired;
   logic                      w_mismatch;
   logic                      w_last_idx;

   assign w_start_pass    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
   assign w_timer_expired = (r_timer == c_TMR_LAST);
   assign w_last_idx      = (r_idx == c_IDX_LAST);
   assign w_mismatch      = (r_rd_pixel != {{(SDRAM_DATA_W-PIXEL_W){1'b0}}, rom_pixel});
   // A new pass starts at pixel 0; otherwise the next request is the following pixel.
   assign w_req_idx       = w_start_pass ? '0 : (r_idx + ROM_ADDR_W'(1));

   // Next-state selection; a read strobe beats a timeout firing on the same cycle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_next = ST_REQ;
         ST_REQ:  w_state_next = ST_WAIT;
         ST_WAIT: begin
            if (read_valid)           w_state_next = ST_CMP;
            else if (w_timer_expired) w_state_next = ST_DONE;
         end
         ST_CMP:  w_state_next = w_last_idx ? ST_DONE : ST_REQ;
         ST_DONE: if (start) w_state_next = ST_REQ;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_50MHz or negedge reset_sync_143) begin
      if (!reset_sync_143) r_state <= ST_IDLE;
      else                 r_state <= w_state_next;
   end

   // Datapath and registered outputs, derived from the upcoming state so they align with it
   always_ff @(posedge clk_50MHz or negedge reset_sync_143) begin
      if (!reset_sync_143) begin
         r_idx          <= '0;
         r_timer        <= '0;
         r_rd_pixel     <= '0;
         start_read     <= 1'b0;
         read_addr      <= '0;
         rom_addr       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         error_count    <= '0;
         first_err_addr <= '0;
      end else begin
         busy       <= (w_state_next == ST_REQ) || (w_state_next == ST_WAIT) ||
                       (w_state_next == ST_CMP);
         start_read <= (w_state_next == ST_REQ);

         if (w_start_pass) begin
            error_count    <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            done           <= 1'b0;
         end

         // Address is launched with the request and held until the compare is finished
         if (w_state_next == ST_REQ) begin
            r_idx     <= w_req_idx;
            read_addr <= BASE_ADDR + {{(SDRAM_ADDR_W-ROM_ADDR_W){1'b0}}, w_req_idx};
            rom_addr  <= w_req_idx;
         end

         case (r_state)
            ST_REQ: r_timer <= '0;
            ST_WAIT: begin
               if (read_valid) begin
                  r_rd_pixel <= read_pixel;
               end else if (w_timer_expired) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  if (error_count == '0) first_err_addr <= r_idx;
               end else begin
                  r_timer <= r_timer + c_TMR_W'(1);
               end
            end
            ST_CMP: begin
               if (w_mismatch) begin
                  if (error_count != '1)  error_count    <= error_count + ERR_W'(1);
                  if (error_count == '0)  first_err_addr <= r_idx;
               end
               if (w_last_idx) begin
                  done <= 1'b1;
                  pass <= (error_count == '0) && !w_mismatch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_readback_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_readback_checker
//  Brief    : Scoreboard bench for sdram_readback_checker with a random-latency
//             SDRAM model, an image ROM model and a saturating-counter twin.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_readback_checker;
   import sdram_vga_pkg::*;

   localparam int          N    = 8;
   localparam int          TMO  = 16;
   localparam logic [19:0] BASE = 20'h00100;

   logic        clk_50MHz = 1'b0;
   logic        reset_sync_143 = 1'b0;
   logic        start = 1'b0;
   logic        read_valid = 1'b0;
   logic [15:0] read_pixel = '0;
   logic [2:0]  rom_pixel = '0;

   logic        start_read, busy, done, pass, timeout;
   logic [19:0] read_addr;
   logic [16:0] rom_addr, first_err_addr;
   logic [15:0] error_count;

   logic        s_start_read, s_busy, s_done, s_pass, s_timeout;
   logic [19:0] s_read_addr;
   logic [16:0] s_rom_addr, s_first_err_addr;
   logic [1:0]  s_error_count;

   sdram_readback_checker #(.NUM_PIXELS(N), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO), .ERR_W(16)) dut (
      .clk_50MHz(clk_50MHz), .reset_sync_143(reset_sync_143), .start(start),
      .start_read(start_read), .read_addr(read_addr), .read_pixel(read_pixel),
      .read_valid(read_valid), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .error_count(error_count), .first_err_addr(first_err_addr));

   sdram_readback_checker #(.NUM_PIXELS(N), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO), .ERR_W(2)) dut_sat (
      .clk_50MHz(clk_50MHz), .reset_sync_143(reset_sync_143), .start(start),
      .start_read(s_start_read), .read_addr(s_read_addr), .read_pixel(read_pixel),
      .read_valid(read_valid), .rom_addr(s_rom_addr), .rom_pixel(rom_pixel),
      .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout),
      .error_count(s_error_count), .first_err_addr(s_first_err_addr));

   always #10 clk_50MHz = ~clk_50MHz;

   // ---------------- scenario knobs and models ----------------
   logic [2:0]   rom [N];
   logic [15:0]  flip [N];
   logic [N-1:0] corrupt = '0;
   int           silent_idx = -1;
   bit           spur = 1'b0;

   typedef struct {
      logic pass;
      logic tmo;
      int   errs;
      int   first;
   } res_t;

   int   q_idx[$];
   res_t q_res[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Image ROM with one cycle of registered latency
   always @(posedge clk_50MHz) rom_pixel <= rom[rom_addr[2:0]];

   // SDRAM model: answers each request after 1..5 cycles; optional corruption,
   // a never-answered pixel, and stray strobes in the REQ and CMP cycles
   initial begin
      forever begin
         @(negedge clk_50MHz);
         read_valid = 1'b0;
         if (start_read) begin
            int idx;
            int lat;
            idx = int'(read_addr - BASE);
            if (spur) begin
               read_valid = 1'b1;
               read_pixel = 16'($urandom);
            end
            lat = $urandom_range(1, 5);
            repeat (lat) begin
               @(negedge clk_50MHz);
               read_valid = 1'b0;
            end
            if (idx != silent_idx) begin
               read_valid = 1'b1;
               if (idx >= 0 && idx < N)
                  read_pixel = {13'b0, rom[idx]} ^ (corrupt[idx] ? flip[idx] : 16'h0000);
               else
                  read_pixel = 16'hDEAD;
               @(negedge clk_50MHz);
               read_valid = spur;
               if (spur) read_pixel = 16'($urandom);
            end
         end
      end
   end

   // Reference model: derive the request list and final verdict from the pass description
   task automatic push_expect();
      res_t r;
      int   last;
      bit   found;
      r.pass = 1'b0; r.tmo = 1'b0; r.errs = 0; r.first = 0;
      found = 1'b0;
      last = (silent_idx >= 0) ? silent_idx : N - 1;
      for (int i = 0; i <= last; i++) begin
         q_idx.push_back(i);
         if (i == silent_idx) begin
            r.tmo = 1'b1;
            if (!found) r.first = i;
         end else if (corrupt[i]) begin
            r.errs++;
            if (!found) begin
               r.first = i;
               found = 1'b1;
            end
         end
      end
      r.pass = (r.errs == 0) && !r.tmo;
      q_res.push_back(r);
   endtask

   // Monitor: compares each request and each completed pass against the scoreboard
   initial begin
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk_50MHz);
         if (start_read) begin
            if (q_idx.size() == 0) begin
               check("unexpected_start_read", read_addr, 32'hFFFF_FFFF);
            end else begin
               int   i;
               logic [19:0] ea;
               i  = q_idx.pop_front();
               ea = BASE + 20'(i);
               check("read_addr", read_addr, ea);
               check("rom_addr", rom_addr, 17'(i));
               check("sat_read_addr", s_read_addr, ea);
            end
         end
         if (done && !prev_done) begin
            if (q_res.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               res_t r;
               r = q_res.pop_front();
               check("pass", pass, r.pass);
               check("timeout", timeout, r.tmo);
               check("error_count", error_count, r.errs);
               check("first_err_addr", first_err_addr, r.first);
               check("busy_at_done", busy, 1'b0);
               check("sat_error_count", s_error_count, (r.errs > 3) ? 3 : r.errs);
               check("sat_pass", s_pass, r.pass);
               check("sat_first_err_addr", s_first_err_addr, r.first);
               check("sat_done", s_done, 1'b1);
            end
         end
         prev_done = done;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic check_zero(input string tag);
      check({tag, "_start_read"}, start_read, 0);
      check({tag, "_read_addr"}, read_addr, 0);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_error_count"}, error_count, 0);
      check({tag, "_first_err_addr"}, first_err_addr, 0);
      check({tag, "_sat_error_count"}, s_error_count, 0);
      check({tag, "_sat_busy"}, s_busy, 0);
   endtask

   task automatic new_rom();
      for (int i = 0; i < N; i++) begin
         rom[i]  = 3'($urandom);
         flip[i] = 16'h8000;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_50MHz);
      start = 1'b0;
   endtask

   task automatic wait_read(input int idx);
      int n = 0;
      while (!(start_read && read_addr == BASE + 20'(idx)) && n < 400) begin
         @(negedge clk_50MHz);
         n++;
      end
      if (n >= 400) check("wait_read_bound", 0, 1);
   endtask

   task automatic finish_pass(input string tag);
      int n = 0;
      while (!done && n < 600) begin
         @(negedge clk_50MHz);
         n++;
      end
      if (!done) check({tag, "_done_bound"}, done, 1);
      repeat (4) @(negedge clk_50MHz);
      check({tag, "_done_held"}, done, 1);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_pending_reads"}, q_idx.size(), 0);
      check({tag, "_pending_results"}, q_res.size(), 0);
   endtask

   task automatic run_pass(input string tag);
      push_expect();
      pulse_start();
      finish_pass(tag);
   endtask

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      new_rom();
      repeat (3) @(negedge clk_50MHz);
      check_zero("reset");
      reset_sync_143 = 1'b1;
      repeat (2) @(negedge clk_50MHz);
      check_zero("idle");

      // All words match
      run_pass("match");

      // Pixels 3 and 6 corrupted in bit 15
      new_rom();
      corrupt = 8'b0100_1000;
      run_pass("corrupt36");

      // Pixel 5 never answered
      corrupt = '0;
      silent_idx = 5;
      run_pass("silent5");
      silent_idx = -1;

      // Stray strobes plus a start pulse while busy
      new_rom();
      spur = 1'b1;
      push_expect();
      pulse_start();
      wait_read(2);
      pulse_start();
      finish_pass("stray");
      spur = 1'b0;

      // Reset while waiting on pixel 4, then a fresh pass
      push_expect();
      pulse_start();
      wait_read(4);
      @(negedge clk_50MHz);
      reset_sync_143 = 1'b0;
      #1;
      check_zero("midreset");
      q_idx.delete();
      q_res.delete();
      repeat (2) @(negedge clk_50MHz);
      check_zero("midreset_held");
      reset_sync_143 = 1'b1;
      repeat (10) @(negedge clk_50MHz);
      run_pass("after_reset");

      // Every pixel corrupted: saturating twin stops at 3
      new_rom();
      corrupt = '1;
      run_pass("all_bad");

      // Randomized passes
      for (int k = 0; k < 8; k++) begin
         new_rom();
         corrupt = N'($urandom);
         for (int i = 0; i < N; i++) begin
            flip[i] = 16'($urandom);
            if (flip[i] == 16'h0000) flip[i] = 16'h0001;
         end
         silent_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
         spur = 1'($urandom_range(0, 1));
         run_pass("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
